serial_subtractor: RTL and testbench

//  - Bit-serial N-bit unsigned subtractor computing Difference = A - B, LSB first, one bit per clock.
//  - Sits one stage above the 1-bit half/full subtractor cells: it feeds one bit pair plus the stored borrow per cycle.
//  - Trades latency for area; the arithmetic datapath is a single 1-bit full-subtract slice.

---
 rtl/serial_subtractor.sv | 113 +++++++++++
 tb/tb_serial_subtractor.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one full-subtract slice per clock.
// Optional signed overflow output: define SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  Clk,
    input  logic                  Reset_n_In,
    input  logic                  Start_In,
    input  logic [DATA_WIDTH-1:0] Data_A_In,
    input  logic [DATA_WIDTH-1:0] Data_B_In,
    output logic                  Ready_Out,
    output logic                  Valid_Out,
    output logic [DATA_WIDTH-1:0] Difference_Out,
    output logic                  Borrow_Out
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic                  Overflow_Out
`endif
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] a_sr, b_sr, res_sr, res_nxt;
    logic [CW-1:0]         cnt;
    logic                  borrow, borrow_nxt, d_bit;
    logic                  last_bit;

    always_ff @(posedge Clk) begin
        if (!Reset_n_In) state <= IDLE;
        else             state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (Start_In) state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The single 1-bit full-subtract slice
    always_comb begin
        d_bit      = a_sr[0] ^ b_sr[0] ^ borrow;
        borrow_nxt = (~a_sr[0] & b_sr[0])
                   | (~(a_sr[0] ^ b_sr[0]) & borrow);
        res_nxt    = {d_bit, {(DATA_WIDTH-1){1'b0}}} | (res_sr >> 1);
        last_bit   = (cnt == LAST);
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n_In) begin
            a_sr           <= '0;
            b_sr           <= '0;
            res_sr         <= '0;
            borrow         <= 1'b0;
            cnt            <= '0;
            Difference_Out <= '0;
            Borrow_Out     <= 1'b0;
        end else if (state == IDLE) begin
            if (Start_In) begin
                a_sr   <= Data_A_In;
                b_sr   <= Data_B_In;
                res_sr <= '0;
                borrow <= 1'b0;
                cnt    <= '0;
            end
        end else if (state == SHIFT) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= res_nxt;
            borrow <= borrow_nxt;
            cnt    <= cnt + CW'(1);
            if (last_bit) begin
                Difference_Out <= res_nxt;
                Borrow_Out     <= borrow_nxt;
            end
        end
    end

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic a_msb, b_msb;

    // Operand sign bits are gone from the shifters by the end, so keep them
    always_ff @(posedge Clk) begin
        if (!Reset_n_In) begin
            a_msb        <= 1'b0;
            b_msb        <= 1'b0;
            Overflow_Out <= 1'b0;
        end else if (state == IDLE) begin
            if (Start_In) begin
                a_msb <= Data_A_In[DATA_WIDTH-1];
                b_msb <= Data_B_In[DATA_WIDTH-1];
            end
        end else if (state == SHIFT && last_bit) begin
            Overflow_Out <= (a_msb != b_msb) && (d_bit != a_msb);
        end
    end
`endif

    assign Ready_Out = (state == IDLE);
    assign Valid_Out = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed corners plus random ops.
// Overflow checks are compiled in with SERIAL_SUB_OVERFLOW_EN.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] da, db;
    logic         ready, valid, borrow;
    logic [W-1:0] diff;
    logic         ovf;

    int checks = 0;
    int passed = 0;
    int vcnt   = 0;
    logic prev_valid = 1'b0;

    typedef struct {
        logic [W-1:0] diff;
        logic         borrow;
        logic         ovf;
    } exp_t;

    exp_t sb[$];

    serial_subtractor #(.DATA_WIDTH(W)) dut (
        .Clk           (clk),
        .Reset_n_In    (rst_n),
        .Start_In      (start),
        .Data_A_In     (da),
        .Data_B_In     (db),
        .Ready_Out     (ready),
        .Valid_Out     (valid),
        .Difference_Out(diff),
        .Borrow_Out    (borrow)
`ifdef SERIAL_SUB_OVERFLOW_EN
        ,
        .Overflow_Out  (ovf)
`endif
    );

`ifndef SERIAL_SUB_OVERFLOW_EN
    assign ovf = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Reference: plain integer arithmetic, unsigned and signed
    function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b);
        exp_t e;
        int   ua, ub, sa, sb_, sr;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 2 ** (W - 1)) ? ua - 2 ** W : ua;
        sb_ = (ub >= 2 ** (W - 1)) ? ub - 2 ** W : ub;
        sr = sa - sb_;
        e.borrow = (ua < ub);
        e.diff   = W'((ua - ub + 2 ** W) % (2 ** W));
        e.ovf    = (sr > 2 ** (W - 1) - 1) || (sr < -(2 ** (W - 1)));
        return e;
    endfunction

    always @(negedge clk) begin
        if (valid) begin
            exp_t e;
            chk("valid_single", prev_valid, 0);
            vcnt++;
            if (sb.size() == 0) begin
                chk("sb_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("difference", diff, e.diff);
                chk("borrow", borrow, e.borrow);
`ifdef SERIAL_SUB_OVERFLOW_EN
                chk("overflow", ovf, e.ovf);
`endif
            end
        end
        prev_valid = valid;
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk("ready_timeout", ready, 1);
    endtask

    // Returns at the negedge following the accepting edge
    task automatic do_op(logic [W-1:0] a, logic [W-1:0] b, bit push);
        wait_ready();
        start = 1'b1;
        da    = a;
        db    = b;
        if (push) sb.push_back(model(a, b));
        @(negedge clk);
        start = 1'b0;
        da    = W'($urandom);
        db    = W'($urandom);
    endtask

    initial begin
        #1ms;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1, "timeout");
    end

    initial begin
        int v0;
        rst_n = 1'b0;
        start = 1'b0;
        da    = '0;
        db    = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_ready", ready, 1);
        chk("rst_valid", valid, 0);
        chk("rst_diff", diff, 0);
        chk("rst_borrow", borrow, 0);
        chk("rst_ovf", ovf, 0);

        // Latency: Valid after 8 more edges, Ready one edge later
        do_op(8'h05, 8'h03, 1);
        repeat (7) @(negedge clk);
        chk("lat_valid_early", valid, 0);
        @(negedge clk);
        chk("lat_valid", valid, 1);
        chk("lat_ready_busy", ready, 0);
        @(negedge clk);
        chk("lat_ready", ready, 1);
        chk("lat_valid_drop", valid, 0);
        chk("held_diff", diff, 8'h02);

        do_op(8'h03, 8'h05, 1);
        do_op(8'h00, 8'h01, 1);
        do_op(8'hFF, 8'hFF, 1);
        do_op(8'h80, 8'h01, 1);
        do_op(8'h7F, 8'hFF, 1);
        wait_ready();

        // Start while busy must be ignored
        v0 = vcnt;
        do_op(8'h10, 8'h01, 1);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        da    = 8'hAA;
        db    = 8'h55;
        @(negedge clk);
        start = 1'b0;
        wait_ready();
        @(negedge clk);
        chk("busy_start_pulses", vcnt - v0, 1);
        chk("busy_start_diff", diff, 8'h0F);

        // Reset mid-run aborts with no Valid pulse
        v0 = vcnt;
        do_op(8'h9C, 8'h21, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_ready", ready, 1);
        chk("abort_valid", valid, 0);
        chk("abort_diff", diff, 0);
        chk("abort_borrow", borrow, 0);
        chk("abort_ovf", ovf, 0);
        repeat (12) @(negedge clk);
        chk("abort_no_valid", vcnt - v0, 0);

        for (int i = 0; i < 1000; i++) begin
            do_op(W'($urandom), W'($urandom), 1);
        end
        wait_ready();
        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
